// File: rtl/sys_mem_responder_pkg.sv
// Shared constants, register selects and byte-merge helper for sys_mem_responder.
package sys_mem_responder_pkg;

  localparam logic [31:0] MTIME_LO_OFS    = 32'h0000_0000;
  localparam logic [31:0] MTIME_HI_OFS    = 32'h0000_0004;
  localparam logic [31:0] MTIMECMP_LO_OFS = 32'h0000_0008;
  localparam logic [31:0] MTIMECMP_HI_OFS = 32'h0000_000C;
  localparam logic [31:0] MSIP_OFS        = 32'h0000_0010;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

  typedef enum logic [1:0] {
    ISRC_NOP  = 2'd0,
    ISRC_RAM  = 2'd1,
    ISRC_ZERO = 2'd2
  } isrc_e;

  typedef enum logic [2:0] {
    REG_NONE        = 3'd0,
    REG_MTIME_LO    = 3'd1,
    REG_MTIME_HI    = 3'd2,
    REG_MTIMECMP_LO = 3'd3,
    REG_MTIMECMP_HI = 3'd4,
    REG_MSIP        = 3'd5
  } mmio_reg_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  // ofs is the byte offset from the timer base; the low two bits are ignored.
  function automatic mmio_reg_e mmio_decode(input logic [31:0] ofs);
    mmio_reg_e r;
    case ({ofs[31:2], 2'b00})
      MTIME_LO_OFS:    r = REG_MTIME_LO;
      MTIME_HI_OFS:    r = REG_MTIME_HI;
      MTIMECMP_LO_OFS: r = REG_MTIMECMP_LO;
      MTIMECMP_HI_OFS: r = REG_MTIMECMP_HI;
      MSIP_OFS:        r = REG_MSIP;
      default:         r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dp_byte_ram.sv
// Dual-port RAM: port A read-only, port B read/write with byte mask.
// Both ports are synchronous read-first so the array maps onto block RAM.
module dp_byte_ram #(
  parameter int WORDS = 2048,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] a_addr,
  output logic [31:0]   a_rdata,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [3:0]    b_mask,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;

  always_ff @(posedge clk) begin
    a_rdata_q <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    b_rdata_q <= mem[b_addr];
    for (int i = 0; i < 4; i++) begin
      if (b_we && b_mask[i]) begin
        mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/sys_mem_responder.sv
// Instruction/data responder: byte-writable RAM plus memory-mapped machine timer
// (mtime/mtimecmp) and software-interrupt register.
module sys_mem_responder
  import sys_mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 2048,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] I_ADDR,
  output logic [31:0] INSTR,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] DATA_OUT,
  input  logic        WR_REQ,
  input  logic [3:0]  WR_MASK,
  output logic [31:0] DATA_IN,
  output logic [63:0] REAL_TIME,
  output logic        T_IRQ,
  output logic        S_IRQ
);

  localparam int            AW        = $clog2(MEM_WORDS);
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [31:0] ram_a_rdata;
  logic [31:0] ram_b_rdata;
  logic        i_in_ram;
  logic        d_in_ram;
  logic        ram_we;
  mmio_reg_e   d_reg;
  logic [3:0]  wr_mask_eff;
  logic        tick;
  logic [63:0] mtime_next;

  isrc_e       isrc_q,       isrc_d;
  logic        d_from_ram_q, d_from_ram_d;
  logic [31:0] d_mmio_q,     d_mmio_d;
  logic [PW-1:0] presc_q,    presc_d;
  logic [63:0] mtime_q,      mtime_d;
  logic [63:0] mtimecmp_q,   mtimecmp_d;
  logic        msip_q,       msip_d;
  logic        t_irq_q,      t_irq_d;
  logic        s_irq_q,      s_irq_d;

  logic unused_iaddr_lsb;
  assign unused_iaddr_lsb = ^I_ADDR[1:0];

  dp_byte_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (CLK),
    .a_addr  (I_ADDR[AW+1:2]),
    .a_rdata (ram_a_rdata),
    .b_addr  (D_ADDR[AW+1:2]),
    .b_we    (ram_we),
    .b_mask  (WR_MASK),
    .b_wdata (DATA_OUT),
    .b_rdata (ram_b_rdata)
  );

  // Address decode and write qualification
  always_comb begin
    i_in_ram    = (I_ADDR[31:AW+2] == {(30-AW){1'b0}});
    d_in_ram    = (D_ADDR[31:AW+2] == {(30-AW){1'b0}});
    d_reg       = d_in_ram ? REG_NONE : mmio_decode(D_ADDR - MMIO_BASE);
    ram_we      = WR_REQ && d_in_ram;
    wr_mask_eff = WR_REQ ? WR_MASK : 4'h0;
  end

  // Prescaler, timer registers and msip; a tick is applied before any write merge
  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? {PW{1'b0}} : presc_q + PW'(1);
    mtime_next = tick ? mtime_q + 64'd1 : mtime_q;
    mtime_d    = mtime_next;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    case (d_reg)
      REG_MTIME_LO:    mtime_d[31:0]     = byte_merge(mtime_next[31:0], DATA_OUT, wr_mask_eff);
      REG_MTIME_HI:    mtime_d[63:32]    = byte_merge(mtime_next[63:32], DATA_OUT, wr_mask_eff);
      REG_MTIMECMP_LO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], DATA_OUT, wr_mask_eff);
      REG_MTIMECMP_HI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], DATA_OUT, wr_mask_eff);
      REG_MSIP:        msip_d            = wr_mask_eff[0] ? DATA_OUT[0] : msip_q;
      default:         msip_d            = msip_q;
    endcase
    t_irq_d = (mtime_q >= mtimecmp_q);
    s_irq_d = msip_q;
  end

  // Read-side selects; MMIO reads see pre-edge register values
  always_comb begin
    isrc_d       = i_in_ram ? ISRC_RAM : ISRC_ZERO;
    d_from_ram_d = d_in_ram;
    case (d_reg)
      REG_MTIME_LO:    d_mmio_d = mtime_q[31:0];
      REG_MTIME_HI:    d_mmio_d = mtime_q[63:32];
      REG_MTIMECMP_LO: d_mmio_d = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: d_mmio_d = mtimecmp_q[63:32];
      REG_MSIP:        d_mmio_d = {31'd0, msip_q};
      default:         d_mmio_d = 32'h0000_0000;
    endcase
  end

  // State registers; RAM writes are outside this block so they survive RESET
  always_ff @(posedge CLK) begin
    if (RESET) begin
      isrc_q       <= ISRC_NOP;
      d_from_ram_q <= 1'b0;
      d_mmio_q     <= 32'h0000_0000;
      presc_q      <= {PW{1'b0}};
      mtime_q      <= 64'h0;
      mtimecmp_q   <= {64{1'b1}};
      msip_q       <= 1'b0;
      t_irq_q      <= 1'b0;
      s_irq_q      <= 1'b0;
    end else begin
      isrc_q       <= isrc_d;
      d_from_ram_q <= d_from_ram_d;
      d_mmio_q     <= d_mmio_d;
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      t_irq_q      <= t_irq_d;
      s_irq_q      <= s_irq_d;
    end
  end

  // Output mux over registered selects and RAM read registers
  always_comb begin
    case (isrc_q)
      ISRC_NOP: INSTR = NOP_INSTR;
      ISRC_RAM: INSTR = ram_a_rdata;
      default:  INSTR = 32'h0000_0000;
    endcase
    DATA_IN = d_from_ram_q ? ram_b_rdata : d_mmio_q;
  end

  assign REAL_TIME = mtime_q;
  assign T_IRQ     = t_irq_q;
  assign S_IRQ     = s_irq_q;

endmodule
